// File: rtl/seg_debug_pkg.sv
// Shared constants for the debug seven-segment display: source select codes and
// the active-low hex glyph table.
package seg_debug_pkg;

    localparam logic [2:0] SEL_PC     = 3'd0;
    localparam logic [2:0] SEL_INSTR  = 3'd1;
    localparam logic [2:0] SEL_RDATA1 = 3'd2;
    localparam logic [2:0] SEL_RDATA2 = 3'd3;
    localparam logic [2:0] SEL_IM     = 3'd4;
    localparam logic [2:0] SEL_ALU    = 3'd5;
    localparam logic [2:0] SEL_BLANK  = 3'd6;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return HEX_GLYPH[nib];
    endfunction

endpackage

// File: rtl/seg_debug_display_btn_debounce.sv
// Step button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            // Level only changes after an unbroken run of differing samples
            if (sync_p1 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/seg_debug_display.sv
// Switch-selected 16-bit view of processor buses on the 4-digit multiplexed
// seven-segment display, plus the debounced single-step pulse.
import seg_debug_pkg::*;

module seg_debug_display #(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] rdata1_in,
    input  logic [31:0] rdata2_in,
    input  logic [31:0] im_in,
    input  logic [31:0] alu_in,
    input  logic [2:0]  sel,
    input  logic        half,
    input  logic        step_btn,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        step_pulse
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [31:0]   src;
    logic [15:0]   slice;
    logic [15:0]   snap_p0;
    logic          blank_p0;
    logic [3:0]    nib;

    always_comb begin
        src = '0;
        case (sel)
            SEL_PC:     src = pc_in;
            SEL_INSTR:  src = instr_in;
            SEL_RDATA1: src = rdata1_in;
            SEL_RDATA2: src = rdata2_in;
            SEL_IM:     src = im_in;
            SEL_ALU:    src = alu_in;
            default:    src = '0;
        endcase
        slice = half ? src[31:16] : src[15:0];
        nib   = snap_p0[{digit_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            snap_p0     <= '0;
            blank_p0    <= 1'b0;
            an          <= 4'b1111;
            seg         <= BLANK_SEG;
            dp          <= 1'b1;
        end else begin
            // Stage A: scan position and once-per-scan snapshot
            if (refresh_cnt == REFRESH_MAX) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (refresh_cnt == '0 && digit_idx == 2'd0) begin
                snap_p0  <= slice;
                blank_p0 <= (sel >= SEL_BLANK);
            end
            // Stage B: registered display drive from pre-edge stage A
            an  <= ~(4'b0001 << digit_idx);
            seg <= blank_p0 ? BLANK_SEG : hex_glyph(nib);
            dp  <= ~(digit_idx == 2'd3 && half);
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .pulse(step_pulse)
    );

endmodule

// File: tb/tb_seg_debug_display.sv
// Scoreboard bench for seg_debug_display with a scan-time / run-length reference model.
module tb_seg_debug_display;

    localparam int R = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0, instr_in = '0, rdata1_in = '0, rdata2_in = '0, im_in = '0, alu_in = '0;
    logic [2:0]  sel = '0;
    logic        half = 1'b0;
    logic        step_btn = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        step_pulse;

    seg_debug_display #(.REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .rdata1_in(rdata1_in),
        .rdata2_in(rdata2_in), .im_in(im_in), .alu_in(alu_in), .sel(sel), .half(half),
        .step_btn(step_btn), .an(an), .seg(seg), .dp(dp), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pulse;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pulse_seen = 0;
    int   cyc_no = 0;

    logic [6:0] glyph_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: edges since reset release, snapshot, button history
    int          n = 0;
    logic [15:0] m_snap = '0;
    bit          m_blank = 0;
    bit          h1 = 0, h2 = 0, lvl = 0, rose_prev = 0;
    int          run = 0;

    function automatic logic [15:0] src16();
        logic [31:0] v;
        case (sel)
            3'd0: v = pc_in;
            3'd1: v = instr_in;
            3'd2: v = rdata1_in;
            3'd3: v = rdata2_in;
            3'd4: v = im_in;
            3'd5: v = alu_in;
            default: v = 32'h0;
        endcase
        return half ? v[31:16] : v[15:0];
    endfunction

    task automatic model_edge(output exp_t e);
        int digit;
        if (rst) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pulse: 1'b0};
            n = 0; m_snap = '0; m_blank = 0;
            h1 = 0; h2 = 0; lvl = 0; run = 0; rose_prev = 0;
        end else begin
            n++;
            digit = ((n - 1) / R) % 4;
            e.an  = 4'hF & ~(4'h1 << digit);
            e.seg = m_blank ? 7'h7F : glyph_tb[(m_snap >> (4 * digit)) & 16'hF];
            e.dp  = !(digit == 3 && half);
            if ((n - 1) % (4 * R) == 0) begin
                m_snap  = src16();
                m_blank = (sel >= 3'd6);
            end
            e.pulse   = rose_prev;
            rose_prev = 0;
            if (h2 != lvl) begin
                run++;
                if (run == D) begin
                    lvl = h2; run = 0; rose_prev = h2;
                end
            end else begin
                run = 0;
            end
            h2 = h1;
            h1 = step_btn;
        end
    endtask

    // Inputs are set after a negedge; this records the expectation and advances one edge
    task automatic cyc();
        exp_t e;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (step_pulse === 1'b1) pulse_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", 32'(an), 32'(e.an));
                check("seg", 32'(seg), 32'(e.seg));
                check("dp", 32'(dp), 32'(e.dp));
                check("step_pulse", 32'(step_pulse), 32'(e.pulse));
            end
        end
    end

    initial begin : stimulus
        int p0;
        int hold;
        @(negedge clk);

        // Scan of pc = 0x1234
        pc_in = 32'h0000_1234; sel = 3'd0; half = 1'b0; rst = 1'b1;
        run_cycles(3);
        rst = 1'b0;
        run_cycles(40);

        // Upper half of instr with decimal point
        rst = 1'b1; run_cycles(1); rst = 1'b0;
        instr_in = 32'hABCD_EF01; sel = 3'd1; half = 1'b1;
        run_cycles(36);

        // Mid-scan change must wait for the next snapshot
        rst = 1'b1; half = 1'b0; sel = 3'd5; alu_in = 32'h0000_0005; run_cycles(1); rst = 1'b0;
        run_cycles(6);
        alu_in = 32'h0000_0009;
        run_cycles(30);

        // Blank select
        sel = 3'd6;
        run_cycles(36);

        // Bouncy press, clean hold, release, second press
        p0 = pulse_seen;
        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 3) % 2) != 0;
            cyc();
        end
        step_btn = 1'b1; run_cycles(30);
        step_btn = 1'b0; run_cycles(20);
        step_btn = 1'b1; run_cycles(30);
        step_btn = 1'b0; run_cycles(20);
        check("pulse_count", 32'(pulse_seen - p0), 32'd2);

        // Reset in digit 2 while the debounce counter is partway
        sel = 3'd0; pc_in = 32'h0000_4321;
        rst = 1'b1; run_cycles(1); rst = 1'b0;
        run_cycles(2);
        step_btn = 1'b1;
        run_cycles(7);
        rst = 1'b1; run_cycles(1); rst = 1'b0;
        run_cycles(30);
        step_btn = 1'b0;
        run_cycles(20);

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                pc_in = $urandom; instr_in = $urandom; rdata1_in = $urandom;
                rdata2_in = $urandom; im_in = $urandom; alu_in = $urandom;
            end
            if ($urandom_range(0, 30) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 30) == 0) half = 1'($urandom_range(0, 1));
            if (hold == 0) begin
                step_btn = ~step_btn;
                hold = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(8, 25);
            end else begin
                hold--;
            end
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        run_cycles(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
